// File: rtl/ex_stage.sv
// ex_stage -- MIPS-style execute stage (ID/EX -> EX/MEM register).
//
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   RegDstIN..RegWriteIN, ALUOpIN  control from the ID/EX register
//   nextPcIN, readData1IN,
//   readData2IN, signExtIN         PC+4, rs, rt, sign-extended immediate
//   ins20_16IN, ins15_11IN         rt / rd register numbers
//   *OUT (except stallOUT)         registered EX/MEM outputs
//   stallOUT                       combinational; asks upstream to hold
//
// Optional feature: define EX_MULT_EN to build a 32-cycle shift-add
// multiplier selected by R-type funct 011000. Without it the stage is purely
// single-cycle and stallOUT is tied low.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RegDstIN,
  input  logic        BranchIN,
  input  logic        MemReadIN,
  input  logic        MemtoRegIN,
  input  logic        MemWriteIN,
  input  logic        ALUSrcIN,
  input  logic        RegWriteIN,
  input  logic [1:0]  ALUOpIN,
  input  logic [31:0] nextPcIN,
  input  logic [31:0] readData1IN,
  input  logic [31:0] readData2IN,
  input  logic [31:0] signExtIN,
  input  logic [4:0]  ins20_16IN,
  input  logic [4:0]  ins15_11IN,
  output logic        BranchOUT,
  output logic        MemReadOUT,
  output logic        MemtoRegOUT,
  output logic        MemWriteOUT,
  output logic        RegWriteOUT,
  output logic [31:0] branchTargetOUT,
  output logic [31:0] aluResultOUT,
  output logic [31:0] writeDataOUT,
  output logic        zeroOUT,
  output logic [4:0]  writeRegOUT,
  output logic        stallOUT
);

  // Everything forwarded to MEM that does not depend on the ALU result.
  typedef struct packed {
    logic        br;
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        rw;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic [31:0] tgt;
  } ctl_t;

  typedef struct packed {
    ctl_t        ctl;
    logic [31:0] res;
    logic        zero;
  } out_t;

  logic [31:0] opa, opb, alu_res;
  logic [5:0]  funct;
  ctl_t        cur_ctl;
  out_t        out_d, oq;

  assign opa   = readData1IN;
  assign opb   = ALUSrcIN ? signExtIN : readData2IN;
  assign funct = signExtIN[5:0];

  always_comb begin
    alu_res = 32'd0;
    case (ALUOpIN)
      2'b01: alu_res = opa - opb;
      2'b10: begin
        case (funct)
          6'b100000: alu_res = opa + opb;
          6'b100010: alu_res = opa - opb;
          6'b100100: alu_res = opa & opb;
          6'b100101: alu_res = opa | opb;
          6'b100111: alu_res = ~(opa | opb);
          6'b101010: alu_res = {31'd0, $signed(opa) < $signed(opb)};
          default:   alu_res = 32'd0;
        endcase
      end
      default: alu_res = opa + opb; // 00 add, 11 reserved -> add
    endcase
  end

  always_comb begin
    cur_ctl.br    = BranchIN;
    cur_ctl.mr    = MemReadIN;
    cur_ctl.m2r   = MemtoRegIN;
    cur_ctl.mw    = MemWriteIN;
    cur_ctl.rw    = RegWriteIN;
    cur_ctl.wreg  = RegDstIN ? ins15_11IN : ins20_16IN;
    cur_ctl.wdata = readData2IN;
    cur_ctl.tgt   = nextPcIN + {signExtIN[29:0], 2'b00};
  end

`ifdef EX_MULT_EN
  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_d;
  logic        mul_dec, last;
  logic [4:0]  cnt;
  logic [31:0] ma, mb, acc, acc_nxt;
  ctl_t        hld;

  assign mul_dec = (ALUOpIN == 2'b10) && (funct == 6'b011000);
  assign last    = (cnt == 5'd31);
  // One partial product per BUSY cycle; the last one is folded in
  // combinationally so the product lands on the edge leaving BUSY.
  assign acc_nxt = acc + (mb[cnt] ? (ma << cnt) : 32'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d  = state;
    stallOUT = 1'b0;
    case (state)
      IDLE: if (mul_dec) begin
        state_d  = BUSY;
        stallOUT = 1'b1;
      end
      BUSY: begin
        if (last) state_d  = IDLE;
        else      stallOUT = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
      ma  <= '0;
      mb  <= '0;
      hld <= '0;
    end else if (state == IDLE) begin
      if (mul_dec) begin
        cnt <= '0;
        acc <= '0;
        ma  <= opa;
        mb  <= opb;
        hld <= cur_ctl;
      end
    end else begin
      acc <= acc_nxt;
      cnt <= cnt + 5'd1;
    end
  end

  always_comb begin
    out_d.ctl  = cur_ctl;
    out_d.res  = alu_res;
    out_d.zero = (alu_res == 32'd0);
    if (state == BUSY && last) begin
      out_d.ctl  = hld;
      out_d.res  = acc_nxt;
      out_d.zero = (acc_nxt == 32'd0);
    end else if (stallOUT) begin
      // Bubble: kill side-effecting control, leave the rest as it was.
      out_d        = oq;
      out_d.ctl.br = 1'b0;
      out_d.ctl.mr = 1'b0;
      out_d.ctl.mw = 1'b0;
      out_d.ctl.rw = 1'b0;
    end
  end
`else
  assign stallOUT = 1'b0;

  always_comb begin
    out_d.ctl  = cur_ctl;
    out_d.res  = alu_res;
    out_d.zero = (alu_res == 32'd0);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) oq <= '0;
    else        oq <= out_d;
  end

  assign BranchOUT       = oq.ctl.br;
  assign MemReadOUT      = oq.ctl.mr;
  assign MemtoRegOUT     = oq.ctl.m2r;
  assign MemWriteOUT     = oq.ctl.mw;
  assign RegWriteOUT     = oq.ctl.rw;
  assign writeRegOUT     = oq.ctl.wreg;
  assign writeDataOUT    = oq.ctl.wdata;
  assign branchTargetOUT = oq.ctl.tgt;
  assign aluResultOUT    = oq.res;
  assign zeroOUT         = oq.zero;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage -- directed + randomized scoreboard bench for ex_stage.
// Multiply and mid-multiply reset scenarios are built when EX_MULT_EN is set.
module tb_ex_stage;

  typedef struct packed {
    logic        regdst, branch, memread, memtoreg, memwrite, alusrc, regwrite;
    logic [1:0]  aluop;
    logic [31:0] npc, rs, rt, sx;
    logic [4:0]  rtn, rdn;
  } in_t;

  typedef struct packed {
    logic        br, mr, m2r, mw, rw;
    logic [31:0] tgt, res, wdata;
    logic        zero;
    logic [4:0]  wreg;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  in_t  cur = '0;
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic        BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT;
  logic [31:0] branchTargetOUT, aluResultOUT, writeDataOUT;
  logic        zeroOUT, stallOUT;
  logic [4:0]  writeRegOUT;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .RegDstIN(cur.regdst), .BranchIN(cur.branch), .MemReadIN(cur.memread),
    .MemtoRegIN(cur.memtoreg), .MemWriteIN(cur.memwrite), .ALUSrcIN(cur.alusrc),
    .RegWriteIN(cur.regwrite), .ALUOpIN(cur.aluop), .nextPcIN(cur.npc),
    .readData1IN(cur.rs), .readData2IN(cur.rt), .signExtIN(cur.sx),
    .ins20_16IN(cur.rtn), .ins15_11IN(cur.rdn),
    .BranchOUT(BranchOUT), .MemReadOUT(MemReadOUT), .MemtoRegOUT(MemtoRegOUT),
    .MemWriteOUT(MemWriteOUT), .RegWriteOUT(RegWriteOUT),
    .branchTargetOUT(branchTargetOUT), .aluResultOUT(aluResultOUT),
    .writeDataOUT(writeDataOUT), .zeroOUT(zeroOUT), .writeRegOUT(writeRegOUT),
    .stallOUT(stallOUT)
  );

  function automatic exp_t model(input in_t i);
    exp_t e;
    logic [31:0] b;
    b = i.alusrc ? i.sx : i.rt;
    case (i.aluop)
      2'b01: e.res = i.rs - b;
      2'b10:
        case (i.sx[5:0])
          6'h20: e.res = i.rs + b;
          6'h22: e.res = i.rs - b;
          6'h24: e.res = i.rs & b;
          6'h25: e.res = i.rs | b;
          6'h27: e.res = ~(i.rs | b);
          6'h2A: e.res = ($signed(i.rs) < $signed(b)) ? 32'd1 : 32'd0;
          default: e.res = 32'd0;
        endcase
      default: e.res = i.rs + b;
    endcase
    e.zero  = (e.res == 32'd0);
    e.br    = i.branch;
    e.mr    = i.memread;
    e.m2r   = i.memtoreg;
    e.mw    = i.memwrite;
    e.rw    = i.regwrite;
    e.tgt   = i.npc + (i.sx << 2);
    e.wdata = i.rt;
    e.wreg  = i.regdst ? i.rdn : i.rtn;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pop the oldest expectation and compare every registered output.
  task automatic cmp(input string tag);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL %s: observed empty scoreboard expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, ".res"},   aluResultOUT,    e.res);
      chk({tag, ".zero"},  zeroOUT,         e.zero);
      chk({tag, ".tgt"},   branchTargetOUT, e.tgt);
      chk({tag, ".wdata"}, writeDataOUT,    e.wdata);
      chk({tag, ".wreg"},  writeRegOUT,     e.wreg);
      chk({tag, ".ctl"}, {BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT},
          {e.br, e.mr, e.m2r, e.mw, e.rw});
    end
  endtask

  // Drive one single-cycle op and compare after the next edge.
  task automatic op1(input string tag, input in_t i);
    cur = i;
    sb.push_back(model(i));
    #1 chk({tag, ".stall"}, stallOUT, 1'b0);
    @(posedge clk); #1;
    cmp(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".res"}, aluResultOUT, 32'd0);
    chk({tag, ".tgt"}, branchTargetOUT, 32'd0);
    chk({tag, ".wdata"}, writeDataOUT, 32'd0);
    chk({tag, ".misc"}, {BranchOUT, MemReadOUT, MemtoRegOUT, MemWriteOUT, RegWriteOUT,
        zeroOUT, writeRegOUT, stallOUT}, 32'd0);
  endtask

  in_t t;
  logic [5:0] fl [7] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h3F};

  initial begin
    // Reset state.
    #3 chk_all_zero("reset");
    #4 rst_n = 1'b1;
    @(posedge clk); #1;

    // R-type sub 5-7.
    t = '0; t.aluop = 2'b10; t.sx = 32'h22; t.rs = 5; t.rt = 7; t.regwrite = 1; t.rtn = 3;
    op1("sub", t);
    chk("sub.const", aluResultOUT, 32'hFFFFFFFE);
    chk("sub.zero", zeroOUT, 1'b0);

    // Branch compare with negative offset.
    t = '0; t.aluop = 2'b01; t.rs = 32'h1234; t.rt = 32'h1234; t.branch = 1;
    t.npc = 32'h100; t.sx = 32'hFFFFFFFF;
    op1("beq", t);
    chk("beq.zero", zeroOUT, 1'b1);
    chk("beq.tgt", branchTargetOUT, 32'hFC);
    chk("beq.br", BranchOUT, 1'b1);

    // Signed slt plus rd selection.
    t = '0; t.aluop = 2'b10; t.sx = 32'h2A; t.rs = 32'h80000000; t.rt = 1;
    t.regdst = 1; t.rdn = 9; t.rtn = 4; t.regwrite = 1;
    op1("slt", t);
    chk("slt.res", aluResultOUT, 32'd1);
    chk("slt.wreg", writeRegOUT, 5'd9);

    // Add wraparound, immediate operand, reserved ALUOp.
    t = '0; t.aluop = 2'b00; t.alusrc = 1; t.rs = 32'hFFFFFFFF; t.sx = 32'h1;
    t.memread = 1; t.memtoreg = 1; t.rt = 32'hABCD; t.npc = 32'hFFFFFFFC;
    op1("addwrap", t);
    chk("addwrap.res", aluResultOUT, 32'd0);
    chk("addwrap.tgt", branchTargetOUT, 32'd0);
    t.aluop = 2'b11; t.rs = 32'h10; t.memwrite = 1;
    op1("rsvd", t);
    chk("rsvd.res", aluResultOUT, 32'h11);

`ifndef EX_MULT_EN
    // Without the multiplier, funct 011000 is an unknown op.
    t = '0; t.aluop = 2'b10; t.sx = 32'h18; t.rs = 7; t.rt = 6; t.regwrite = 1;
    op1("nomul", t);
    chk("nomul.res", aluResultOUT, 32'd0);
`endif

    // Randomized ops, back to back.
    for (int k = 0; k < 24; k++) begin
      t = in_t'({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom});
      t.sx[5:0] = fl[$urandom_range(0, 6)];
      if (k % 4 == 0) t.rt = t.rs;
      if (t.aluop == 2'b10) t.alusrc = 1'b0;
      op1("rand", t);
    end

`ifdef EX_MULT_EN
    begin
      exp_t em;
      // Multiply 0x10001 * 3 presented in cycle T.
      t = '0; t.aluop = 2'b10; t.sx = 32'h18; t.rs = 32'h10001; t.rt = 3;
      t.regwrite = 1; t.regdst = 1; t.rdn = 12; t.npc = 32'h40;
      cur = t;
      em = model(t); em.res = 32'h30003; em.zero = 1'b0;
      sb.push_back(em);
      #1 chk("mul.stallT", stallOUT, 1'b1);
      for (int i = 1; i <= 32; i++) begin
        @(posedge clk); #1;
        chk("mul.bubble", RegWriteOUT, 1'b0);
        chk("mul.stall", stallOUT, (i <= 31) ? 1'b1 : 1'b0);
        if (i == 5) begin
          cur.rs = 32'hDEADBEEF; cur.rt = 32'h77; // must be ignored
          #1 chk("mul.stall_chg", stallOUT, 1'b1);
        end
        if (i == 32) begin
          t = '0; t.rs = 40; t.rt = 2; t.regwrite = 1; t.rtn = 6;
          cur = t;
          sb.push_back(model(t));
        end
      end
      @(posedge clk); #1;
      chk("mul.prod", aluResultOUT, 32'h30003);
      chk("mul.rw", RegWriteOUT, 1'b1);
      cmp("mul");
      chk("after.stall", stallOUT, 1'b0);
      @(posedge clk); #1;
      cmp("after");

      // Reset at BUSY count 10 aborts the multiply.
      t = '0; t.aluop = 2'b10; t.sx = 32'h18; t.rs = 9; t.rt = 9; t.regwrite = 1;
      cur = t;
      for (int i = 0; i < 11; i++) begin @(posedge clk); #1; end
      t = '0; t.rs = 100; t.rt = 23; t.regwrite = 1; t.rtn = 2;
      cur = t;
      rst_n = 1'b0;
      #1 chk_all_zero("abort");
      #2 rst_n = 1'b1;
      op1("post", t);
      chk("post.res", aluResultOUT, 32'd123);
    end
`endif

    chk("sb.drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: the bench must never hang.
  initial begin
    #200000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
